// File: rtl/fl_pkg.sv
// Shared single-precision float definitions for the butterfly datapath
// (multiplier and sequential divider).
package fl_pkg;
  localparam int          FL_BIAS = 127;
  localparam int          FL_EXP  = 8;
  localparam int          FL_MANT = 23;
  localparam logic [31:0] FL_QNAN = 32'h7FC0_0000;
  localparam logic [30:0] FL_INF  = 31'h7F80_0000;

  typedef enum logic [1:0] {NORMAL, ZERO, INF, NAN} fl_class_e;
  typedef enum logic [1:0] {IDLE, DIV, PACK} div_state_e;
endpackage

// File: rtl/fl_unpack.sv
// Splits an IEEE-754 single into fields and classifies it; a zero exponent
// field is flushed to ZERO, so subnormals never reach the datapath.
module fl_unpack
  import fl_pkg::*;
(
  input  logic [31:0]        word,
  output logic               sign,
  output logic [FL_EXP-1:0]  exp,
  output logic [FL_MANT:0]   mant,
  output fl_class_e          cls
);
  logic [FL_MANT-1:0] frac;

  assign sign = word[31];
  assign exp  = word[30:23];
  assign frac = word[22:0];
  assign mant = {(exp != '0), frac};

  always_comb begin
    cls = NORMAL;
    if (exp == '0)             cls = ZERO;
    else if (exp == '1)        cls = (frac == '0) ? INF : NAN;
  end
endmodule

// File: rtl/fldiv_seq.sv
// Sequential single-precision divider: restoring radix-2, one quotient bit
// per cycle, fixed 26-cycle latency, truncating rounding.
module fldiv_seq
  import fl_pkg::*;
#(
  parameter int QBITS = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero
);
  logic              sa, sb;
  logic [FL_EXP-1:0] ea, eb;
  logic [FL_MANT:0]  ma, mb;
  fl_class_e         ca, cb;

  fl_unpack u_unpack_a (.word(a_operand), .sign(sa), .exp(ea), .mant(ma), .cls(ca));
  fl_unpack u_unpack_b (.word(b_operand), .sign(sb), .exp(eb), .mant(mb), .cls(cb));

  div_state_e         state;
  logic [4:0]         cnt;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [FL_MANT:0]   mb_q;
  logic [QBITS-1:0]   rem, q;
  logic               spec_q, spec_dbz_q;
  logic [31:0]        spec_res_q;

  // Special-case decision, taken on the operands at capture time
  logic        spec_d, spec_dbz_d;
  logic [31:0] spec_res_d;
  logic        sgn_d;
  assign sgn_d = sa ^ sb;

  always_comb begin
    spec_d     = 1'b1;
    spec_dbz_d = 1'b0;
    spec_res_d = {sgn_d, FL_INF};
    if (ca == NAN || cb == NAN || (ca == ZERO && cb == ZERO) || (ca == INF && cb == INF))
      spec_res_d = FL_QNAN;
    else if (ca == INF)
      spec_res_d = {sgn_d, FL_INF};
    else if (cb == ZERO)
      spec_dbz_d = 1'b1;
    else if (ca == ZERO || cb == INF)
      spec_res_d = {sgn_d, 31'd0};
    else
      spec_d = 1'b0;
  end

  logic signed [9:0] exp_d;
  assign exp_d = signed'({2'b00, ea}) - signed'({2'b00, eb}) + 10'sd127;

  // Remainder stays below 2*mb, so after a subtract it fits in 24 bits
  logic             ge;
  logic [QBITS-1:0] diff;
  assign ge   = (rem >= {1'b0, mb_q});
  assign diff = ge ? rem - {1'b0, mb_q} : rem;

  logic signed [9:0]  exp_n;
  logic [FL_MANT-1:0] mant_n;
  logic [31:0]        pack_res;
  assign exp_n  = q[QBITS-1] ? exp_q : exp_q - 10'sd1;
  assign mant_n = q[QBITS-1] ? q[FL_MANT:1] : q[FL_MANT-1:0];

  always_comb begin
    pack_res = {sign_q, exp_n[7:0], mant_n};
    if (exp_n >= 10'sd255)    pack_res = {sign_q, FL_INF};
    else if (exp_n <= 10'sd0) pack_res = {sign_q, 31'd0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mb_q        <= '0;
      rem         <= '0;
      q           <= '0;
      spec_q      <= 1'b0;
      spec_dbz_q  <= 1'b0;
      spec_res_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= start;
          if (start) begin
            sign_q     <= sgn_d;
            exp_q      <= exp_d;
            mb_q       <= mb;
            rem        <= {1'b0, ma};
            q          <= '0;
            spec_q     <= spec_d;
            spec_dbz_q <= spec_dbz_d;
            spec_res_q <= spec_res_d;
            cnt        <= '0;
            state      <= DIV;
          end
        end
        DIV: begin
          q   <= {q[QBITS-2:0], ge};
          rem <= {diff[QBITS-2:0], 1'b0};
          cnt <= cnt + 5'd1;
          if (cnt == 5'(QBITS - 1)) state <= PACK;
        end
        PACK: begin
          result      <= spec_q ? spec_res_q : pack_res;
          div_by_zero <= spec_q & spec_dbz_q;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fldiv_seq.sv
// Self-checking bench for fldiv_seq: directed cases plus random operands
// compared against an integer-division reference model.
module tb_fldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_operand = '0, b_operand = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] result;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  fldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_operand(a_operand),
    .b_operand(b_operand), .busy(busy), .done(done), .result(result),
    .div_by_zero(div_by_zero)
  );

  // Reference: quotient from the exact integer ratio of the significands
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e;
    logic s, an, ai, az, bn, bi, bz;
    longint q;
    logic [22:0] m;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    an = (ea == 255) && (a[22:0] != 0); ai = (ea == 255) && (a[22:0] == 0); az = (ea == 0);
    bn = (eb == 255) && (b[22:0] != 0); bi = (eb == 255) && (b[22:0] == 0); bz = (eb == 0);
    if (an || bn || (az && bz) || (ai && bi)) return {1'b0, 32'h7FC00000};
    if (ai) return {1'b0, s, 31'h7F800000};
    if (bz) return {1'b1, s, 31'h7F800000};
    if (az || bi) return {1'b0, s, 31'd0};
    q = (longint'({1'b1, a[22:0]}) << 24) / longint'({1'b1, b[22:0]});
    e = ea - eb + 127;
    if (q >= 64'd16777216) m = q[23:1];
    else begin m = q[22:0]; e = e - 1; end
    if (e >= 255) return {1'b0, s, 31'h7F800000};
    if (e <= 0) return {1'b0, s, 31'd0};
    return {1'b0, s, e[7:0], m};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    a_operand = a; b_operand = b; start = 1'b1;
  endtask

  // Waits for the accepting edge, then counts edges until done (bounded)
  task automatic wait_done(output int lat, output logic [31:0] r, output logic d);
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!done && lat < 40);
    r = result; d = div_by_zero;
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_r, input logic exp_d);
    int lat; logic [31:0] r; logic d;
    @(negedge clk); issue(a, b);
    wait_done(lat, r, d);
    chk({tag, " result"}, r, exp_r);
    chk({tag, " dbz"}, {31'd0, d}, {31'd0, exp_d});
    chk({tag, " latency"}, lat, 26);
  endtask

  initial begin
    int lat, n, ndone;
    logic [31:0] r, a, b;
    logic d;
    logic [32:0] m;

    #12;
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset result", result, 32'h0);
    chk("reset dbz", {31'd0, div_by_zero}, 0);
    rst_n = 1'b1;

    run("4/2",      32'h40800000, 32'h40000000, 32'h40000000, 1'b0);
    run("1/3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);
    run("3/2",      32'h40400000, 32'h40000000, 32'h3FC00000, 1'b0);
    run("-1/4",     32'hBF800000, 32'h40800000, 32'hBE800000, 1'b0);
    run("6/1.5",    32'h40C00000, 32'h3FC00000, 32'h40800000, 1'b0);
    run("1/0",      32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1);
    run("0/0",      32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0);
    run("0/-x",     32'h00000000, 32'hC1526666, 32'h80000000, 1'b0);
    run("ovf",      32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0);
    run("unf",      32'h00800000, 32'h7F000000, 32'h00000000, 1'b0);
    run("nan",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0);
    run("inf/inf",  32'hFF800000, 32'h7F800000, 32'h7FC00000, 1'b0);
    run("-inf/x",   32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0);
    run("inf/0",    32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0);
    run("x/inf",    32'h40000000, 32'hFF800000, 32'h80000000, 1'b0);
    run("ftz/x",    32'h00400000, 32'h3F800000, 32'h00000000, 1'b0);

    for (int i = 0; i < 24; i++) begin
      a = {$urandom_range(0, 1) == 1, 8'($urandom_range(60, 195)), 23'($urandom)};
      b = {$urandom_range(0, 1) == 1, 8'($urandom_range(60, 195)), 23'($urandom)};
      if (i % 8 == 7) b = $urandom;
      if (i % 8 == 3) a = $urandom;
      m = ref_div(a, b);
      run("rand", a, b, m[31:0], m[32]);
    end

    // start pulsed mid-operation must be ignored
    @(negedge clk); issue(32'h40400000, 32'h40000000);
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    do begin
      @(posedge clk); n++; #1;
      start = (n == 5);
      if (n == 5) begin a_operand = 32'h3F800000; b_operand = 32'h00000000; end
    end while (!done && n < 40);
    start = 1'b0;
    chk("busy-start result", result, 32'h3FC00000);
    chk("busy-start latency", n, 26);
    ndone = 0;
    repeat (30) begin @(posedge clk); #1; if (done) ndone++; end
    chk("busy-start extra done", ndone, 0);

    // back-to-back: start held in the done cycle
    run("b2b first", 32'h40800000, 32'h40000000, 32'h40000000, 1'b0);
    issue(32'h3F800000, 32'h40400000);
    wait_done(lat, r, d);
    chk("b2b second result", r, 32'h3EAAAAAA);
    chk("b2b second latency", lat + 1, 27);

    // reset abort mid-operation
    @(negedge clk); issue(32'h40C00000, 32'h3FC00000);
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy}, 0);
    chk("abort result", result, 32'h0);
    chk("abort done", {31'd0, done}, 0);
    #2 rst_n = 1'b1;
    ndone = 0;
    repeat (35) begin @(posedge clk); #1; if (done) ndone++; end
    chk("abort no done", ndone, 0);

    run("post-abort", 32'h40800000, 32'h40000000, 32'h40000000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
